magcomp_sweep_driver: RTL and testbench



---
 rtl/magcomp_pkg.sv | 21 ++
 rtl/magcomp_sweep_driver_if.sv | 13 +
 rtl/magcomp_ref.sv | 14 +
 rtl/magcomp_sweep_driver.sv | 148 ++++++++++++++
 tb/tb_magcomp_sweep_driver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/magcomp_pkg.sv
// Shared types and helpers for the magnitude-comparator sweep driver/checker.
package magcomp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Number of operand pairs in an exhaustive sweep of two w-bit operands.
    function automatic int unsigned vec_count(input int unsigned w);
        return 32'd1 << (2 * w);
    endfunction

    // Expected {lt, gt, eq} for unsigned operands (up to 8 bits, zero-extended by caller).
    function automatic logic [2:0] exp_flags(input logic [7:0] a, input logic [7:0] b);
        return {a < b, a > b, a == b};
    endfunction

endpackage

// File: rtl/magcomp_sweep_driver_if.sv
// Operand/flag bus between the sweep driver (master) and a magnitude comparator (slave).
interface magcomp_sweep_driver_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             lt_i;
    logic             gt_i;
    logic             eq_i;

    modport master (output a_o, output b_o, input lt_i, input gt_i, input eq_i);
    modport slave  (input a_o, input b_o, output lt_i, output gt_i, output eq_i);
endinterface

// File: rtl/magcomp_ref.sv
// Combinational expected-flag generator for an unsigned magnitude comparator.
module magcomp_ref
    import magcomp_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [2:0]       flags_o
);

    assign flags_o = exp_flags(8'(a_i), 8'(b_i));

endmodule

// File: rtl/magcomp_sweep_driver.sv
// Exhaustive sweep driver/checker for a magnitude comparator.
// Optional MAGCOMP_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module magcomp_sweep_driver
    import magcomp_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    magcomp_sweep_driver_if.master cmp,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH:0]       pass_cnt,
    output logic [2*WIDTH:0]       fail_cnt,
    output logic                   first_fail_vld,
    output logic [2*WIDTH+2:0]     first_fail_vec
);

    localparam int          CW        = 2 * WIDTH + 1;
    localparam int          VW        = 2 * WIDTH;
    localparam int unsigned NVEC      = vec_count(WIDTH);
    localparam logic [3:0]  HOLD_LAST = 4'(SETTLE_CYC - 1);

    state_e             state_q, state_d;
    logic [3:0]         hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]      pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic               ffv_q, ffv_d;
    logic [CW+1:0]      ffvec_q, ffvec_d;

    logic [2:0]         exp_w;
    logic [2:0]         obs_w;
    logic               vec_ok;
    logic               last_vec;
    logic               stop_now;

    magcomp_ref #(.WIDTH(WIDTH)) u_ref (
        .a_i     (a_q),
        .b_i     (b_q),
        .flags_o (exp_w)
    );

    assign obs_w    = {cmp.lt_i, cmp.gt_i, cmp.eq_i};
    assign vec_ok   = (obs_w == exp_w);
    assign last_vec = ({a_q, b_q} == VW'(NVEC - 1));
`ifdef MAGCOMP_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = last_vec || !vec_ok;
`else
    assign stop_now = last_vec;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HOLD;
                    hold_cnt_d = 4'd0;
                    a_d        = '0;
                    b_d        = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    ffv_d      = 1'b0;
                    ffvec_d    = '0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = CHECK;
                else                         hold_cnt_d = hold_cnt_q + 4'd1;
            end
            CHECK: begin
                if (vec_ok) begin
                    pass_cnt_d = pass_cnt_q + CW'(1);
                end else begin
                    fail_cnt_d = fail_cnt_q + CW'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = {a_q, b_q, obs_w};
                    end
                end
                // Operands are left on the final (or failing) pair when the sweep ends.
                if (stop_now) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = HOLD;
                    hold_cnt_d = 4'd0;
                    {a_d, b_d} = {a_q, b_q} + VW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffvec_q    <= ffvec_d;
        end
    end

    assign cmp.a_o        = a_q;
    assign cmp.b_o        = b_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_vec = ffvec_q;

endmodule

// File: tb/tb_magcomp_sweep_driver.sv
// Randomized self-checking bench for magcomp_sweep_driver against a sweep-level reference model.
module tb_magcomp_sweep_driver;

    localparam int W  = 2;
    localparam int S  = 1;
    localparam int NV = 1 << (2 * W);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           busy, done, ffv;
    logic [2*W:0]   pass_cnt, fail_cnt;
    logic [2*W+2:0] ffvec;

    int             mode;
    logic [2:0]     fault_tbl [NV];
    logic [2:0]     cmp_flags;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    magcomp_sweep_driver_if #(.WIDTH(W)) cif ();

    magcomp_sweep_driver #(.WIDTH(W), .SETTLE_CYC(S)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cmp            (cif.master),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_vld (ffv),
        .first_fail_vec (ffvec)
    );

    // Comparator under test: 0 correct, 1 eq stuck low, 2 lt/gt swapped, 3 table-driven faults.
    function automatic logic [2:0] cmp_resp(input int md, input int a, input int b, input logic [2:0] tbl);
        logic lt, gt, eq;
        lt = (a < b);
        gt = (a > b);
        eq = (a == b);
        case (md)
            1:       return {lt, gt, 1'b0};
            2:       return {gt, lt, eq};
            3:       return tbl;
            default: return {lt, gt, eq};
        endcase
    endfunction

    always_comb begin
        cmp_flags = cmp_resp(mode, int'(cif.a_o), int'(cif.b_o), fault_tbl[{cif.a_o, cif.b_o}]);
    end
    assign cif.lt_i = cmp_flags[2];
    assign cif.gt_i = cmp_flags[1];
    assign cif.eq_i = cmp_flags[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else             n_pass++;
    endtask

    // Walk every pair in sweep order and predict what the checker should report.
    task automatic model_sweep(output int e_pass, output int e_fail, output int e_ffv,
                               output int e_ffvec, output int e_cyc, output int e_a, output int e_b);
        int checked;
        logic [2:0] obs, good;
        e_pass = 0; e_fail = 0; e_ffv = 0; e_ffvec = 0; checked = 0; e_a = 0; e_b = 0;
        for (int idx = 0; idx < NV; idx++) begin
            int a, b;
            a    = idx / (1 << W);
            b    = idx % (1 << W);
            obs  = cmp_resp(mode, a, b, fault_tbl[idx]);
            good = {a < b, a > b, a == b};
            checked++;
            e_a = a;
            e_b = b;
            if (obs == good) begin
                e_pass++;
            end else begin
                e_fail++;
                if (e_ffv == 0) begin
                    e_ffv   = 1;
                    e_ffvec = (a << (W + 3)) | (b << 3) | int'(obs);
                end
`ifdef MAGCOMP_SWEEP_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        e_cyc = checked * (S + 1);
    endtask

    task automatic run_sweep(input int md, input bit repulse);
        int e_pass, e_fail, e_ffv, e_ffvec, e_cyc, e_a, e_b;
        int busy_cyc, cyc;
        mode = md;
        model_sweep(e_pass, e_fail, e_ffv, e_ffvec, e_cyc, e_a, e_b);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_cnt_clr", {pass_cnt, fail_cnt, ffv}, 0);
        busy_cyc = 0;
        cyc      = 0;
        while (!done && cyc < 400) begin
            if (busy) busy_cyc++;
            start = (repulse && busy_cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("sweep_done", done, 1);
        chk("sweep_len", busy_cyc, e_cyc);
        chk("end_busy", busy, 0);
        chk("pass_cnt", pass_cnt, e_pass);
        chk("fail_cnt", fail_cnt, e_fail);
        chk("ff_vld", ffv, e_ffv);
        chk("ff_vec", ffvec, e_ffvec);
        chk("a_hold", cif.a_o, e_a);
        chk("b_hold", cif.b_o, e_b);
        repeat (2) @(negedge clk);
        chk("done_sticky", done, 1);
        chk("cnt_sticky", pass_cnt + fail_cnt, e_pass + e_fail);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        for (int i = 0; i < NV; i++) fault_tbl[i] = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_ffv", ffv, 0);
        chk("rst_ffvec", ffvec, 0);
        chk("rst_ab", {cif.a_o, cif.b_o}, 0);

        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NV; i++) begin
                int a, b;
                a = i / (1 << W);
                b = i % (1 << W);
                fault_tbl[i] = {a < b, a > b, a == b};
            end
            for (int k = 0; k < 3; k++) fault_tbl[$urandom_range(0, NV - 1)] = 3'($urandom_range(0, 7));
            run_sweep(3, 1'b0);
        end

        // Reset in the middle of a sweep.
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cnt", {pass_cnt, fail_cnt}, 0);
        chk("midrst_ff", {ffv, ffvec}, 0);
        chk("midrst_ab", {cif.a_o, cif.b_o}, 0);
        run_sweep(0, 1'b0);

        // Start coincident with reset is dropped.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_start_busy", busy, 0);
        @(negedge clk);
        chk("rst_start_idle", busy, 0);
        chk("rst_start_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
